tract_w: RTL

TRACT_W -- requirements
Module: tract_w

---
 rtl/tract_w_pkg.sv | 21 ++
 rtl/tract_w_result_mux_w.sv | 23 ++
 rtl/tract_w.sv | 87 ++++++++
 3 files changed

// File: rtl/tract_w_pkg.sv
// Shared pipeline definitions for the writeback stage: result-source encodings
// and the MEM/WB control register layout.
package tract_w_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef struct packed {
    logic       valid;
    logic       regwrite;
    logic [1:0] resultsrc;
    logic [4:0] rd;
  } mem_wb_ctrl_t;

  // A register-file write only happens for a live instruction targeting a non-x0 register.
  function automatic logic wb_writes(mem_wb_ctrl_t c);
    return c.regwrite & c.valid & (c.rd != 5'd0);
  endfunction

endpackage

// File: rtl/tract_w_result_mux_w.sv
// Writeback result selector; the reserved encoding falls back to the ALU result.
module result_mux_w
  import tract_w_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            resultsrc,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] read_data,
  input  logic [DATA_WIDTH-1:0] pc_plus4,
  output logic [DATA_WIDTH-1:0] result
);

  always_comb begin
    result = alu_result;
    case (resultsrc)
      RES_MEM: result = read_data;
      RES_PC4: result = pc_plus4;
      default: result = alu_result;
    endcase
  end

endmodule

// File: rtl/tract_w.sv
// MEM/WB pipeline register and writeback stage.
// Optional retirement counter and InstRetW port enabled by TRACT_W_INSTRET_EN.
module tract_w
  import tract_w_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  StallW,
  input  logic                  FlushW,
  input  logic                  ValidM,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic [31:0]           RdM,
  input  logic [DATA_WIDTH-1:0] ALUResultMW,
  input  logic [DATA_WIDTH-1:0] ReadPartDataM,
  input  logic [DATA_WIDTH-1:0] PCPlus4M,
  output logic [DATA_WIDTH-1:0] ResultW,
  output logic [4:0]            RdW,
  output logic                  RegWriteW,
  output logic                  ValidW
`ifdef TRACT_W_INSTRET_EN
  ,
  output logic [63:0]           InstRetW
`endif
);

  mem_wb_ctrl_t          ctrl_q;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] mem_q;
  logic [DATA_WIDTH-1:0] pc4_q;

  logic unused_rd_hi;
  assign unused_rd_hi = ^RdM[31:5];

  // Flush only kills the control bits; data fields are don't-care for a bubble and are simply held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q <= '0;
      alu_q  <= '0;
      mem_q  <= '0;
      pc4_q  <= '0;
    end else if (FlushW) begin
      ctrl_q.valid    <= 1'b0;
      ctrl_q.regwrite <= 1'b0;
    end else if (!StallW) begin
      ctrl_q.valid     <= ValidM;
      ctrl_q.regwrite  <= RegWriteM;
      ctrl_q.resultsrc <= ResultSrcM;
      ctrl_q.rd        <= RdM[4:0];
      alu_q            <= ALUResultMW;
      mem_q            <= ReadPartDataM;
      pc4_q            <= PCPlus4M;
    end
  end

  result_mux_w #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_result_mux (
    .resultsrc (ctrl_q.resultsrc),
    .alu_result(alu_q),
    .read_data (mem_q),
    .pc_plus4  (pc4_q),
    .result    (ResultW)
  );

  assign RdW       = ctrl_q.rd;
  assign ValidW    = ctrl_q.valid;
  assign RegWriteW = wb_writes(ctrl_q);

`ifdef TRACT_W_INSTRET_EN
  logic [63:0] instret_q;

  // The WB occupant retires whenever it leaves; a flush only affects the incoming slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else if (ctrl_q.valid && !StallW) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign InstRetW = instret_q;
`endif

endmodule
